// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : seg_pkg
// Brief    : Glyph codes, 7-segment patterns and BCD sizing helper shared by
//            the seg_scan_disp display driver.
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    typedef enum logic [3:0] {
        D0, D1, D2, D3, D4, D5, D6, D7, D8, D9, G_BLANK, G_MINUS
    } glyph_e;

    // Active-high gfedcba patterns
    localparam logic [6:0] c_seg_0     = 7'h3F;
    localparam logic [6:0] c_seg_1     = 7'h06;
    localparam logic [6:0] c_seg_2     = 7'h5B;
    localparam logic [6:0] c_seg_3     = 7'h4F;
    localparam logic [6:0] c_seg_4     = 7'h66;
    localparam logic [6:0] c_seg_5     = 7'h6D;
    localparam logic [6:0] c_seg_6     = 7'h7D;
    localparam logic [6:0] c_seg_7     = 7'h07;
    localparam logic [6:0] c_seg_8     = 7'h7F;
    localparam logic [6:0] c_seg_9     = 7'h6F;
    localparam logic [6:0] c_seg_minus = 7'h40;
    localparam logic [6:0] c_seg_blank = 7'h00;

    function automatic logic [6:0] glyph_seg(input glyph_e g);
        logic [6:0] s;
        case (g)
            D0:      s = c_seg_0;
            D1:      s = c_seg_1;
            D2:      s = c_seg_2;
            D3:      s = c_seg_3;
            D4:      s = c_seg_4;
            D5:      s = c_seg_5;
            D6:      s = c_seg_6;
            D7:      s = c_seg_7;
            D8:      s = c_seg_8;
            D9:      s = c_seg_9;
            G_MINUS: s = c_seg_minus;
            default: s = c_seg_blank;
        endcase
        return s;
    endfunction

    // Decimal digits needed to represent 2^width-1
    function automatic int bcd_digits(input int width);
        longint unsigned v;
        int              n;
        v = (64'd1 << width) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 0) begin
                v = v / 10;
                n = n + 1;
            end
        end
        if (n == 0) n = 1;
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module   : seg_bin2bcd
// Brief    : Sequential double-dabble converter, one shift-add-3 per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module seg_bin2bcd
    import seg_pkg::*;
#(
    parameter int DATA_W  = 27,
    parameter int BCD_DIG = bcd_digits(DATA_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_W-1:0]      bin,
    output logic                   done,
    output logic [4*BCD_DIG-1:0]   bcd
);

    localparam int c_cnt_w = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]    r_bin;
    logic [4*BCD_DIG-1:0] r_bcd;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_run;
    logic                 r_done;
    logic [4*BCD_DIG-1:0] w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_DIG; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_bin <= bin;
                r_bcd <= '0;
                r_cnt <= '0;
                r_run <= 1'b1;
            end else if (r_run) begin
                r_bcd <= (w_adj << 1) | {{(4*BCD_DIG-1){1'b0}}, r_bin[DATA_W-1]};
                r_bin <= r_bin << 1;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_cnt_w'(DATA_W - 1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/seg_scan_disp.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_disp
// Brief    : Multiplexed 7-segment driver: load handshake, sequential BCD
//            conversion, blanking/sign/dp/overflow, digit scanning.
// Options  : SEG_DIM_EN adds bright[3:0] for per-dwell PWM dimming.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_disp
    import seg_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int N_DIG       = 8,
    parameter int DATA_W      = 27,
    parameter int SEG_ACT_LOW = 1,
    parameter int SEL_ACT_LOW = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         neg,
    input  logic [$clog2(N_DIG+1)-1:0]   dp_pos,
    input  logic                         load,
    output logic                         busy,
    input  logic                         en,
`ifdef SEG_DIM_EN
    input  logic [3:0]                   bright,
`endif
    output logic                         ovf,
    output logic [N_DIG-1:0]             seg_sel,
    output logic [7:0]                   seg_led
);

    localparam int c_bcd_dig   = bcd_digits(DATA_W);
    localparam int c_dpw       = $clog2(N_DIG + 1);
    localparam int c_dwell_raw = CLK_HZ / SCAN_HZ;
    localparam int c_dwell     = (c_dwell_raw < 2) ? 2 : c_dwell_raw;
    localparam int c_dwell_w   = $clog2(c_dwell);
    localparam int c_idx_w     = $clog2(N_DIG);
    localparam int c_ext_dig   = (c_bcd_dig > N_DIG) ? c_bcd_dig : N_DIG;
    localparam int c_pos_w     = 6;
    localparam logic [7:0]       c_led_off = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIG-1:0] c_sel_off = (SEL_ACT_LOW != 0) ? {N_DIG{1'b1}} : {N_DIG{1'b0}};

    logic                     r_busy;
    logic                     r_cap_neg;
    logic [c_dpw-1:0]         r_cap_dp;
    logic [4*c_ext_dig-1:0]   r_disp_bcd;
    logic                     r_disp_neg;
    logic [c_dpw-1:0]         r_disp_dp;
    logic [c_pos_w-1:0]       r_disp_top;
    logic                     r_ovf;
    logic [c_dwell_w-1:0]     r_dwell;
    logic [c_idx_w-1:0]       r_idx;
    logic [N_DIG-1:0]         r_sel;
    logic [7:0]               r_led;

    logic                     w_accept;
    logic                     w_conv_done;
    logic [4*c_bcd_dig-1:0]   w_conv_bcd;
    logic [c_pos_w-1:0]       w_msd;
    logic [c_pos_w-1:0]       w_new_top;
    logic                     w_new_ovf;
    logic [c_pos_w-1:0]       w_pos;
    logic [3:0]               w_digit;
    glyph_e                   w_glyph;
    logic                     w_dp;
    logic [7:0]               w_led_act;
    logic [N_DIG-1:0]         w_onehot;
    logic                     w_wrap;
    logic                     w_on;

    assign w_accept = load & ~r_busy;

    seg_bin2bcd #(
        .DATA_W  (DATA_W),
        .BCD_DIG (c_bcd_dig)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (w_accept),
        .bin   (data_in),
        .done  (w_conv_done),
        .bcd   (w_conv_bcd)
    );

    // Highest shown digit is the larger of the top nonzero digit and the dp digit
    always_comb begin
        w_msd = '0;
        for (int i = 0; i < c_bcd_dig; i++) begin
            if (w_conv_bcd[4*i +: 4] != 4'd0)
                w_msd = c_pos_w'(i);
        end
        w_new_top = w_msd;
        if (r_cap_dp != '0 && (c_pos_w'(r_cap_dp) - c_pos_w'(1)) > w_msd)
            w_new_top = c_pos_w'(r_cap_dp) - c_pos_w'(1);
        w_new_ovf = (w_new_top + c_pos_w'(r_cap_neg)) >= c_pos_w'(N_DIG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_cap_neg  <= 1'b0;
            r_cap_dp   <= '0;
            r_disp_bcd <= '0;
            r_disp_neg <= 1'b0;
            r_disp_dp  <= '0;
            r_disp_top <= '0;
            r_ovf      <= 1'b0;
        end else if (w_accept) begin
            r_busy    <= 1'b1;
            r_cap_neg <= neg;
            r_cap_dp  <= dp_pos;
        end else if (w_conv_done) begin
            r_busy     <= 1'b0;
            r_disp_bcd <= (4*c_ext_dig)'(w_conv_bcd);
            r_disp_neg <= r_cap_neg;
            r_disp_dp  <= r_cap_dp;
            r_disp_top <= w_new_top;
            r_ovf      <= w_new_ovf;
        end
    end

    always_comb begin
        w_pos   = c_pos_w'(r_idx);
        w_digit = r_disp_bcd[4*r_idx +: 4];
        w_glyph = G_BLANK;
        w_dp    = 1'b0;
        if (r_ovf) begin
            w_glyph = G_MINUS;
        end else if (w_pos <= r_disp_top) begin
            w_glyph = glyph_e'(w_digit);
            w_dp    = (r_disp_dp != '0) && (c_pos_w'(r_disp_dp) == w_pos + c_pos_w'(1));
        end else if (r_disp_neg && w_pos == r_disp_top + c_pos_w'(1)) begin
            w_glyph = G_MINUS;
        end
        w_led_act = {w_dp, glyph_seg(w_glyph)};
        w_onehot  = {{(N_DIG-1){1'b0}}, 1'b1} << r_idx;
    end

    assign w_wrap = (r_dwell == c_dwell_w'(c_dwell - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell <= '0;
            r_idx   <= '0;
        end else if (w_wrap) begin
            r_dwell <= '0;
            r_idx   <= (r_idx == c_idx_w'(N_DIG - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

`ifdef SEG_DIM_EN
    logic [3:0]  r_bright;
    logic [3:0]  w_bright_eff;
    logic [31:0] w_thr;

    // First cycle of a dwell uses the live input; the rest of the dwell the sample
    assign w_bright_eff = (r_dwell == '0) ? bright : r_bright;
    assign w_thr        = ((32'(w_bright_eff) + 32'd1) * 32'(c_dwell)) >> 4;
    assign w_on         = 32'(r_dwell) < w_thr;

    always_ff @(posedge clk) begin
        if (rst)
            r_bright <= 4'hF;
        else if (r_dwell == '0)
            r_bright <= bright;
    end
`else
    assign w_on = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= c_sel_off;
            r_led <= c_led_off;
        end else if (en && w_on) begin
            r_sel <= w_onehot ^ c_sel_off;
            r_led <= w_led_act ^ c_led_off;
        end else begin
            r_sel <= c_sel_off;
            r_led <= c_led_off;
        end
    end

    assign busy    = r_busy;
    assign ovf     = r_ovf;
    assign seg_sel = r_sel;
    assign seg_led = r_led;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_disp.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_disp
// Brief    : Self-checking bench for seg_scan_disp (8 digits, 27-bit input,
//            10-cycle dwell, active-low segments and selects).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_disp;

    localparam int N_DIG  = 8;
    localparam int DATA_W = 27;
    localparam int DWELL  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] data_in;
    logic              neg;
    logic [3:0]        dp_pos;
    logic              load;
    logic              busy;
    logic              en;
    logic              ovf;
    logic [N_DIG-1:0]  seg_sel;
    logic [7:0]        seg_led;
`ifdef SEG_DIM_EN
    logic [3:0]        bright;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    seg_scan_disp #(
        .CLK_HZ      (1000),
        .SCAN_HZ     (100),
        .N_DIG       (N_DIG),
        .DATA_W      (DATA_W),
        .SEG_ACT_LOW (1),
        .SEL_ACT_LOW (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .neg     (neg),
        .dp_pos  (dp_pos),
        .load    (load),
        .busy    (busy),
        .en      (en),
`ifdef SEG_DIM_EN
        .bright  (bright),
`endif
        .ovf     (ovf),
        .seg_sel (seg_sel),
        .seg_led (seg_led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] value;
        bit                n;
        int                dp;
        bit                exp_ovf;
        logic [63:0]       exp_frame;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] glyph(input int d);
        case (d)
            0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
            4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
            8: return 8'h7F;  default: return 8'h6F;
        endcase
    endfunction

    // Expected active-low frame, digit 7 in bits 63:56
    function automatic logic [63:0] model(input longint unsigned v, input bit n, input int dp, output bit ov);
        int d[10];
        int msd, top;
        longint unsigned p;
        logic [63:0] f;
        logic [7:0] s;
        p = 1;
        msd = 0;
        for (int i = 0; i < 10; i++) begin
            d[i] = int'((v / p) % 10);
            if (d[i] != 0) msd = i;
            p = p * 10;
        end
        top = (dp > 0 && dp - 1 > msd) ? dp - 1 : msd;
        ov = (top + int'(n)) >= N_DIG;
        for (int i = 0; i < N_DIG; i++) begin
            if (ov)                     s = 8'h40;
            else if (i <= top)          s = glyph(d[i]) | ((dp > 0 && i == dp - 1) ? 8'h80 : 8'h00);
            else if (n && i == top + 1) s = 8'h40;
            else                        s = 8'h00;
            f[i*8 +: 8] = ~s;
        end
        return f;
    endfunction

    task automatic wait_idle;
        int cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            tick();
        end
        check("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic do_load(input longint unsigned v, input bit n, input int dp, output int busy_cycles);
        wait_idle();
        data_in = DATA_W'(v);
        neg     = n;
        dp_pos  = 4'(dp);
        load    = 1'b1;
        tick();
        load    = 1'b0;
        busy_cycles = 0;
        while (busy && busy_cycles < 200) begin
            busy_cycles++;
            tick();
        end
    endtask

    task automatic capture(output logic [63:0] f);
        logic [7:0] seen;
        int bad_sel;
        seen = '0;
        bad_sel = 0;
        f = '1;
        for (int c = 0; c < N_DIG*DWELL + DWELL; c++) begin
            tick();
            if (seg_sel != 8'hFF) begin
                if ($countones(~seg_sel) != 1) bad_sel++;
                else begin
                    for (int k = 0; k < N_DIG; k++) begin
                        if (!seg_sel[k]) begin
                            f[k*8 +: 8] = seg_led;
                            seen[k] = 1'b1;
                        end
                    end
                end
            end
        end
        check("frame_coverage", {56'd0, seen}, 64'h00000000000000FF);
        check("sel_onehot", 64'(bad_sel), 64'd0);
    endtask

    task automatic check_dwell;
        logic [7:0] prev;
        int run, nruns, bad;
        prev = seg_sel;
        run = 0; nruns = 0; bad = 0;
        for (int c = 0; c < 12*DWELL; c++) begin
            tick();
            if (seg_sel == prev) run++;
            else begin
                if (nruns > 0 && run + 1 != DWELL) bad++;
                nruns++;
                run = 0;
                prev = seg_sel;
            end
        end
        check("dwell_len", 64'(bad), 64'd0);
        check("dwell_runs_seen", 64'(nruns >= 10), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] f, mf;
        int bc;
        bit mov;

        vecs[0] = '{27'd1234567,   1'b0, 0, 1'b0, 64'hFFF9A4B0999282F8};
        vecs[1] = '{27'd5,         1'b0, 4, 1'b0, 64'hFFFFFFFF40C0C092};
        vecs[2] = '{27'd42,        1'b1, 0, 1'b0, 64'hFFFFFFFFFFBF99A4};
        vecs[3] = '{27'd100000000, 1'b0, 0, 1'b1, 64'hBFBFBFBFBFBFBFBF};
        vecs[4] = '{27'd9,         1'b1, 0, 1'b0, 64'hFFFFFFFFFFFFBF90};

        rst = 1'b1; load = 1'b0; en = 1'b1; neg = 1'b0; dp_pos = '0; data_in = '0;
`ifdef SEG_DIM_EN
        bright = 4'hF;
`endif
        tick();
        tick();
        check("rst_sel", 64'(seg_sel), 64'hFF);
        check("rst_led", 64'(seg_led), 64'hFF);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        tick();
        check("first_sel", 64'(seg_sel), 64'hFE);
        check("first_led", 64'(seg_led), 64'hC0);
        capture(f);
        check("rst_frame", f, 64'hFFFFFFFFFFFFFFC0);

        for (int v = 0; v < 5; v++) begin
            do_load(64'(vecs[v].value), vecs[v].n, vecs[v].dp, bc);
            check($sformatf("vec%0d_busy_cycles", v), 64'(bc), 64'(DATA_W + 1));
            check($sformatf("vec%0d_ovf", v), 64'(ovf), 64'(vecs[v].exp_ovf));
            capture(f);
            check($sformatf("vec%0d_frame", v), f, vecs[v].exp_frame);
            if (v == 0) check_dwell();
        end

        // load while busy is dropped
        do_load(64'd11, 1'b0, 0, bc);
        wait_idle();
        data_in = 27'd11; neg = 1'b0; dp_pos = '0;
        load = 1'b1; tick(); load = 1'b0;
        repeat (3) tick();
        data_in = 27'd77;
        load = 1'b1; tick(); load = 1'b0;
        wait_idle();
        capture(f);
        check("ignore_busy_load", f, 64'hFFFFFFFFFFFFF9F9);

        // reset mid-conversion
        data_in = 27'd55555; load = 1'b1; tick(); load = 1'b0;
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ovf", 64'(ovf), 64'd0);
        capture(f);
        check("abort_frame", f, 64'hFFFFFFFFFFFFFFC0);

        // display enable
        en = 1'b0; tick();
        check("en0_sel", 64'(seg_sel), 64'hFF);
        check("en0_led", 64'(seg_led), 64'hFF);
        repeat (DWELL) tick();
        check("en0_sel_hold", 64'(seg_sel), 64'hFF);
        en = 1'b1; tick();
        check("en1_active", 64'(seg_sel != 8'hFF), 64'd1);

`ifdef SEG_DIM_EN
        begin
            int on_cnt = 0;
            bright = 4'd3;
            repeat (2*DWELL) tick();
            for (int c = 0; c < N_DIG*DWELL; c++) begin
                tick();
                if (seg_sel != 8'hFF) on_cnt++;
            end
            check("dim_on_cycles", 64'(on_cnt), 64'(N_DIG * ((4 * DWELL) / 16)));
            bright = 4'hF;
        end
`endif

        // randomized loads against the reference model
        for (int r = 0; r < 24; r++) begin
            longint unsigned lim, val;
            bit rn;
            int rdp;
            lim = 1;
            for (int k = 0; k < $urandom_range(1, 9); k++) lim = lim * 10;
            val = longint'($urandom) % lim;
            val = val & ((64'd1 << DATA_W) - 1);
            rn  = 1'($urandom_range(0, 1));
            rdp = $urandom_range(0, N_DIG);
            mf  = model(val, rn, rdp, mov);
            do_load(val, rn, rdp, bc);
            check($sformatf("rnd%0d_busy_cycles", r), 64'(bc), 64'(DATA_W + 1));
            check($sformatf("rnd%0d_ovf", r), 64'(ovf), 64'(mov));
            capture(f);
            check($sformatf("rnd%0d_frame v=%0d n=%0d dp=%0d", r, val, rn, rdp), f, mf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
